bm_memory_fifo_ctrl: RTL and testbench

FIFO controller that sits directly upstream and downstream of the 4-entry BITS-wide simple memory microbenchmark. It drives the memory's write port (address, data, enable) from a valid/ready input stream and reads the memory's combinational read port into a registered valid/ready output stage. Together with the memory, it forms a 4+1-entry first-word-fall-through FIFO used as an ODIN microbenchmark for pointer, counter and handshake logic.

---
 rtl/bm_memory_fifo_ctrl_if.sv | 43 ++++
 rtl/bm_memory_fifo_ctrl.sv | 76 +++++++
 tb/tb_bm_memory_fifo_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/bm_memory_fifo_ctrl_if.sv
//------------------------------------------------------------------------------
// Module : bm_memory_fifo_ctrl_if
// Brief  : Producer stream, consumer stream, memory port and status bundle
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface bm_memory_fifo_ctrl_if #(
    parameter int BITS   = 2,
    parameter int ADDR_W = 2
) ();
    logic              in_valid;
    logic              in_ready;
    logic [BITS-1:0]   in_data;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [BITS-1:0]   mem_wdata;
    logic [ADDR_W-1:0] mem_raddr;
    logic [BITS-1:0]   mem_rdata;

    logic              out_valid;
    logic              out_ready;
    logic [BITS-1:0]   out_data;

    logic              full;
    logic              empty;
    logic [ADDR_W:0]   level;

    modport master (
        input  in_valid, in_data, mem_rdata, out_ready,
        output in_ready, mem_we, mem_waddr, mem_wdata, mem_raddr,
        output out_valid, out_data, full, empty, level
    );

    modport slave (
        output in_valid, in_data, mem_rdata, out_ready,
        input  in_ready, mem_we, mem_waddr, mem_wdata, mem_raddr,
        input  out_valid, out_data, full, empty, level
    );
endinterface

`default_nettype wire

// File: rtl/bm_memory_fifo_ctrl.sv
//------------------------------------------------------------------------------
// Module : bm_memory_fifo_ctrl
// Brief  : Pointer/count controller around a 4-entry memory, FWFT output stage
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bm_memory_fifo_ctrl #(
    parameter int BITS   = 2,
    parameter int ADDR_W = 2,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    bm_memory_fifo_ctrl_if.master bus
);

    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] C_ZERO  = '0;

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_out_valid;
    logic [BITS-1:0]   r_out_data;

    logic              w_in_ready;
    logic              w_push;
    logic              w_load;

    // Load looks only at registered occupancy, so a word written this edge waits one cycle.
    assign w_in_ready = reset_n & ~flush & (r_count != C_DEPTH);
    assign w_push     = bus.in_valid & w_in_ready;
    assign w_load     = (r_count != C_ZERO) & (~r_out_valid | bus.out_ready);

    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_load) begin
                r_out_data  <= bus.mem_rdata;
                r_out_valid <= 1'b1;
                r_rd_ptr    <= r_rd_ptr + 1'b1;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            unique case ({w_push, w_load})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.mem_we    = w_push;
    assign bus.mem_waddr = r_wr_ptr;
    assign bus.mem_wdata = bus.in_data;
    assign bus.mem_raddr = r_rd_ptr;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.full      = (r_count == C_DEPTH);
    assign bus.empty     = (r_count == C_ZERO) & ~r_out_valid;
    assign bus.level     = r_count + {{ADDR_W{1'b0}}, r_out_valid};

endmodule

`default_nettype wire

// File: tb/tb_bm_memory_fifo_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_bm_memory_fifo_ctrl
// Brief  : Directed stimulus with a queue-based FIFO model and literal pins
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bm_memory_fifo_ctrl;

    localparam int BITS   = 2;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;

    logic clock;
    logic reset_n;
    logic flush;

    int n_checks = 0;
    int n_fail   = 0;

    bm_memory_fifo_ctrl_if #(.BITS(BITS), .ADDR_W(ADDR_W)) bus ();

    bm_memory_fifo_ctrl #(.BITS(BITS), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus)
    );

    // The memory the controller is meant to sit around: edge write, combinational read.
    logic [BITS-1:0] mem [DEPTH];
    always_ff @(posedge clock) begin
        if (bus.mem_we) mem[bus.mem_waddr] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = mem[bus.mem_raddr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO model: queued words in memory plus a one-word output register.
    int q[$];
    bit m_ov   = 1'b0;
    int m_od   = 0;
    int m_wcnt = 0;
    int m_rcnt = 0;

    initial begin
        bit rdy, push, load, exp_rdy;
        forever begin
            @(posedge clock);
            rdy  = reset_n && !flush && (q.size() < DEPTH);
            push = bus.in_valid && rdy;
            load = (q.size() > 0) && (!m_ov || bus.out_ready);
            if (!reset_n || flush) begin
                q.delete();
                m_ov = 1'b0; m_od = 0; m_wcnt = 0; m_rcnt = 0;
            end else begin
                if (load) begin
                    m_od = q.pop_front(); m_ov = 1'b1; m_rcnt = (m_rcnt + 1) % DEPTH;
                end else if (m_ov && bus.out_ready) begin
                    m_ov = 1'b0;
                end
                if (push) begin
                    q.push_back(int'(bus.in_data)); m_wcnt = (m_wcnt + 1) % DEPTH;
                end
            end
            @(negedge clock);
            exp_rdy = reset_n && !flush && (q.size() < DEPTH);
            check("in_ready", int'(bus.in_ready), int'(exp_rdy));
            check("mem_we", int'(bus.mem_we), int'(exp_rdy && bus.in_valid));
            if (bus.mem_we) begin
                check("mem_waddr", int'(bus.mem_waddr), m_wcnt);
                check("mem_wdata", int'(bus.mem_wdata), int'(bus.in_data));
            end
            check("mem_raddr", int'(bus.mem_raddr), m_rcnt);
            check("out_valid", int'(bus.out_valid), int'(m_ov));
            check("out_data", int'(bus.out_data), m_od);
            check("full", int'(bus.full), int'(q.size() == DEPTH));
            check("empty", int'(bus.empty), int'(q.size() == 0 && !m_ov));
            check("level", int'(bus.level), q.size() + int'(m_ov));
        end
    end

    // Inputs change just after the falling edge, clear of both sampling points.
    task automatic nxt();
        @(negedge clock);
        #1;
    endtask

    initial begin
        int fill_vals [6] = '{1, 2, 3, 0, 1, 2};
        int pop_vals  [5] = '{1, 2, 3, 0, 1};
        int seen[$];
        int hold_data, hold_level, hold_raddr;

        reset_n      = 1'b0;
        flush        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = '0;
        bus.out_ready = 1'b0;

        repeat (3) nxt();
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_mem_we", int'(bus.mem_we), 0);
        check("rst_empty", int'(bus.empty), 1);
        check("rst_level", int'(bus.level), 0);
        reset_n = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check("rel_in_ready", int'(bus.in_ready), 1);

        // Single word: written at edge k, visible after edge k+1.
        bus.in_valid = 1'b1;
        bus.in_data  = 2'b10;
        #1;
        check("single_we", int'(bus.mem_we), 1);
        check("single_waddr", int'(bus.mem_waddr), 0);
        nxt();
        bus.in_valid = 1'b0;
        check("single_ov_k", int'(bus.out_valid), 0);
        nxt();
        check("single_ov", int'(bus.out_valid), 1);
        check("single_data", int'(bus.out_data), 2);
        check("single_level", int'(bus.level), 1);
        bus.out_ready = 1'b1;
        nxt();
        bus.out_ready = 1'b0;
        check("single_drained", int'(bus.empty), 1);

        // Fill: five accepted, sixth refused.
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = fill_vals[i][1:0];
            nxt();
        end
        check("fill_full", int'(bus.full), 1);
        check("fill_in_ready", int'(bus.in_ready), 0);
        check("fill_level", int'(bus.level), 5);
        check("fill_out_data", int'(bus.out_data), 1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("pop_valid", int'(bus.out_valid), 1);
            check("pop_data", int'(bus.out_data), pop_vals[i]);
            nxt();
            if (i == 0) check("pop_in_ready", int'(bus.in_ready), 1);
        end
        check("pop_empty", int'(bus.empty), 1);

        // Streaming ramp with continuous ready on both sides.
        for (int i = 0; i < 13; i++) begin
            bus.in_valid = (i < 10);
            bus.in_data  = 2'(i % 4);
            if (bus.out_valid && bus.out_ready) seen.push_back(int'(bus.out_data));
            if (bus.level > 2) check("stream_level_le2", int'(bus.level), 2);
            nxt();
        end
        bus.in_valid = 1'b0;
        check("stream_count", seen.size(), 10);
        for (int i = 0; i < seen.size() && i < 10; i++) check("stream_order", seen[i], i % 4);
        check("stream_empty", int'(bus.empty), 1);

        // Flush at level 3 with an input in flight.
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 2'(i);
            nxt();
        end
        check("pre_flush_level", int'(bus.level), 3);
        flush = 1'b1;
        bus.in_data = 2'b11;
        #1;
        check("flush_in_ready", int'(bus.in_ready), 0);
        check("flush_we", int'(bus.mem_we), 0);
        nxt();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_level", int'(bus.level), 0);
        check("flush_empty", int'(bus.empty), 1);
        check("flush_ov", int'(bus.out_valid), 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 2'b01;
        nxt();
        bus.in_valid = 1'b0;
        nxt();
        check("post_flush_ov", int'(bus.out_valid), 1);
        check("post_flush_data", int'(bus.out_data), 1);

        // Backpressure hold.
        for (int i = 2; i <= 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 2'(i);
            nxt();
        end
        bus.in_valid = 1'b0;
        hold_data  = int'(bus.out_data);
        hold_level = int'(bus.level);
        hold_raddr = int'(bus.mem_raddr);
        check("hold_level_val", hold_level, 3);
        for (int i = 0; i < 4; i++) begin
            nxt();
            check("hold_data", int'(bus.out_data), hold_data);
            check("hold_level", int'(bus.level), hold_level);
            check("hold_raddr", int'(bus.mem_raddr), hold_raddr);
        end
        bus.out_ready = 1'b1;
        repeat (4) nxt();
        check("final_empty", int'(bus.empty), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
